sme_match_collector: RTL and testbench
======================================

// Module: sme_match_collector
// PURPOSE
//  Consumer side of the SME match-output interface. Per packet it:
//  - pops every reported rule ID via the valid/release handshake;
//  - buffers up to MAX_MATCHES IDs;
//  - emits a per-packet result message as a 16-bit stream to the core interface;
//  - pulses reload to clear the matcher for the next packet.
// PARAMETERS
//  MAX_MATCHES   8   rule IDs stored per packet; extra matches are released but dropped
//  DRAIN_CYCLES  16  idle cycles after pkt_eop (no capture) before the packet is closed
//  RELEASE_GAP   2   cycles after a release during which match_valid is stale (not sampled)
// PORTS
//  clk            in   1   clock
//  rst            in   1   synchronous active-high reset
//  match_valid    in   1   matcher has a pending rule ID
//  match_rule_ID  in   16  pending rule ID, valid with match_valid
//  match_release  out  1   1-cycle pulse: current ID consumed, matcher advances
//  pkt_eop        in   1   pulse: last beat of current packet accepted by matcher
//  pkt_ready      out  1   high: upstream may stream the next packet into the matcher
//  reload         out  1   1-cycle pulse: clear matcher match mask/FIFO state
//  m_axis_tdata   out  16  result word
//  m_axis_tvalid  out  1   result word valid
//  m_axis_tlast   out  1   last word of the packet's message
//  m_axis_tready  in   1   sink accepts word
// BEHAVIOUR
//  Reset: state=COLLECT; count=0; ovf=0; gap=0; eop_seen=0.
//   All outputs are 0 except pkt_ready=1. reload is NOT pulsed on reset.
//  Reset mid-operation (any state) abandons the message; tvalid is 0 the next cycle.
//  States:
//   COLLECT  wait for matches and pkt_eop.
//   DRAIN    close-out timer running.
//   EMIT     streaming the result message.
//   CLEAR    one cycle, then back to COLLECT.
//  Capture (COLLECT and DRAIN), when match_valid & gap==0:
//   - match_release=1 this cycle; gap<=RELEASE_GAP.
//   - If count<MAX_MATCHES: buf[count]<=match_rule_ID, count++. Else ovf<=1.
//   - gap decrements to 0; while gap!=0, match_valid is ignored.
//  match_release is never asserted outside COLLECT/DRAIN.
//  pkt_eop in COLLECT: eop_seen<=1; next state DRAIN with timer=DRAIN_CYCLES.
//   A capture in the same cycle is still taken.
//  pkt_eop outside COLLECT is a protocol violation and is ignored.
//  DRAIN:
//   - Timer reloads to DRAIN_CYCLES on every capture, otherwise decrements.
//   - Exit to EMIT when timer==0 & gap==0 & !match_valid.
//  pkt_ready = (state==COLLECT) & !eop_seen, registered.
//   Falls the cycle after pkt_eop; rises the cycle after CLEAR.
//  EMIT message:
//   - word0 = {ovf, count[14:0]}; then buf[0..count-1] in capture order.
//   - tlast on the final word (on word0 when count==0).
//   - Words advance only on tvalid&tready.
//   - tdata/tlast are held stable while tvalid & !tready.
//   - Handshake on the tlast word -> CLEAR.
//  CLEAR: reload=1 for exactly one cycle; count, ovf, eop_seen <= 0; next state COLLECT.
//  Latency: first tvalid = 1 cycle after DRAIN exit; reload = 1 cycle after the last handshake.
//  Widths:
//   - count width is clog2(MAX_MATCHES+1); saturates at MAX_MATCHES.
//   - buf is a MAX_MATCHES x 16 register array.
// TESTING
//  T1 No matches: pkt_eop, no match_valid
//     -> after DRAIN_CYCLES, one word 0x0000 with tlast; reload pulse; pkt_ready returns to 1.
//  T2 Three matches: IDs 0x0011, 0x0022, 0x0033 presented, each deasserted 2 cycles after release
//     -> 3 release pulses, message 0x0003,0x0011,0x0022,0x0033 (tlast on 0x0033).
//  T3 Stale valid: match_valid held high continuously with a fixed ID
//     -> release at most once per RELEASE_GAP+1 cycles; no double capture inside the gap.
//  T4 Overflow: 10 matches with MAX_MATCHES=8
//     -> 10 releases, word0=0x8008, first 8 IDs only.
//  T5 Backpressure: tready toggles 1/0 every cycle during EMIT
//     -> tdata stable while stalled; no word lost or duplicated; exactly one reload.
//  T6 Reset mid-EMIT after word1
//     -> tvalid 0 next cycle; no reload; pkt_ready=1; next packet's message is correct.

Source files
------------

// File: rtl/sme_match_collector.sv
// -----------------------------------------------------------------------------
// sme_match_collector
//
// Consumer side of the SME match-output interface. For every packet it pops
// each rule ID the matcher reports (valid/release handshake), keeps the first
// MAX_MATCHES of them, streams a result message to the core once the matcher
// has gone quiet after end-of-packet, and then pulses reload so the matcher
// starts the next packet from a clean state.
//
// Result message: word0 = {overflow, count[14:0]}, followed by the stored
// rule IDs in capture order. tlast marks the final word.
//
// Ports
//   i_clk             clock
//   i_rst             synchronous active-high reset
//   i_match_valid     matcher has a pending rule ID
//   i_match_rule_ID   pending rule ID (valid with i_match_valid)
//   o_match_release   1-cycle pulse: current ID consumed, matcher advances
//   i_pkt_eop         pulse: last beat of the current packet accepted
//   o_pkt_ready       upstream may stream the next packet into the matcher
//   o_reload          1-cycle pulse: clear matcher match mask/FIFO state
//   o_m_axis_tdata    result word
//   o_m_axis_tvalid   result word valid
//   o_m_axis_tlast    last word of the packet's message
//   i_m_axis_tready   sink accepts word
// -----------------------------------------------------------------------------
module sme_match_collector #(
    parameter int MAX_MATCHES  = 8,
    parameter int DRAIN_CYCLES = 16,
    parameter int RELEASE_GAP  = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_match_valid,
    input  logic [15:0] i_match_rule_ID,
    output logic        o_match_release,
    input  logic        i_pkt_eop,
    output logic        o_pkt_ready,
    output logic        o_reload,
    output logic [15:0] o_m_axis_tdata,
    output logic        o_m_axis_tvalid,
    output logic        o_m_axis_tlast,
    input  logic        i_m_axis_tready
);

    localparam int CW = $clog2(MAX_MATCHES + 1);
    localparam int IW = (MAX_MATCHES > 1) ? $clog2(MAX_MATCHES) : 1;
    localparam int TW = (DRAIN_CYCLES > 0) ? $clog2(DRAIN_CYCLES + 1) : 1;
    localparam int GW = (RELEASE_GAP > 0) ? $clog2(RELEASE_GAP + 1) : 1;

    localparam logic [CW-1:0] C_MAX      = CW'(MAX_MATCHES);
    localparam logic [TW-1:0] TIMER_INIT = TW'(DRAIN_CYCLES);
    localparam logic [GW-1:0] GAP_INIT   = GW'(RELEASE_GAP);

    typedef enum logic [1:0] {
        S_COLLECT,
        S_DRAIN,
        S_EMIT,
        S_CLEAR
    } state_t;

    state_t        r_state;
    state_t        w_state_next;

    logic [CW-1:0] r_count;
    logic [CW-1:0] r_widx;
    logic          r_ovf;
    logic          r_eop_seen;
    logic          r_pkt_ready;
    logic [GW-1:0] r_gap;
    logic [TW-1:0] r_timer;
    logic [15:0]   r_buf [MAX_MATCHES];

    logic          w_can_capture;
    logic          w_capture;
    logic          w_room;
    logic          w_eop_seen_next;
    logic          w_reload;
    logic          w_tvalid;
    logic          w_tlast;
    logic [15:0]   w_tdata;
    logic          w_hs;
    logic [IW-1:0] w_rd_idx;

    // After a release the matcher needs RELEASE_GAP cycles before its valid
    // reflects the next entry; r_gap masks that stale window. Reset also
    // masks capture so the matcher never advances while we are being cleared.
    assign w_can_capture = i_match_valid && (r_gap == '0) && !i_rst;
    assign w_room        = (r_count < C_MAX);
    assign w_hs          = w_tvalid && i_m_axis_tready;

    // Word index 0 is the header, so data word k lives in buffer slot k-1.
    // Only the low bits are needed: index MAX_MATCHES wraps to slot MAX-1.
    assign w_rd_idx = r_widx[IW-1:0] - IW'(1);

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_COLLECT;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and output decode.
    always_comb begin
        w_state_next    = r_state;
        w_eop_seen_next = r_eop_seen;
        w_capture       = 1'b0;
        w_tvalid        = 1'b0;
        w_tlast         = 1'b0;
        w_tdata         = '0;
        w_reload        = 1'b0;
        case (r_state)
            S_COLLECT: begin
                w_capture = w_can_capture;
                if (i_pkt_eop) begin
                    w_state_next    = S_DRAIN;
                    w_eop_seen_next = 1'b1;
                end
            end
            S_DRAIN: begin
                w_capture = w_can_capture;
                if ((r_timer == '0) && (r_gap == '0) && !i_match_valid) begin
                    w_state_next = S_EMIT;
                end
            end
            S_EMIT: begin
                w_tvalid = 1'b1;
                w_tlast  = (r_widx == r_count);
                w_tdata  = (r_widx == '0) ? {r_ovf, 15'(r_count)} : r_buf[w_rd_idx];
                if (i_m_axis_tready && w_tlast) begin
                    w_state_next = S_CLEAR;
                end
            end
            S_CLEAR: begin
                w_reload        = 1'b1;
                w_eop_seen_next = 1'b0;
                w_state_next    = S_COLLECT;
            end
            default: begin
                w_state_next = S_COLLECT;
            end
        endcase
    end

    // Packet bookkeeping: capture count/overflow, stale-valid gap, drain
    // timer and the emit word pointer. The drain timer restarts on every
    // capture so the packet is only closed after the matcher has been quiet.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_count     <= '0;
            r_ovf       <= 1'b0;
            r_gap       <= '0;
            r_eop_seen  <= 1'b0;
            r_timer     <= '0;
            r_widx      <= '0;
            r_pkt_ready <= 1'b1;
        end else begin
            r_eop_seen  <= w_eop_seen_next;
            r_pkt_ready <= (w_state_next == S_COLLECT) && !w_eop_seen_next;

            if (w_capture) begin
                r_gap <= GAP_INIT;
            end else if (r_gap != '0) begin
                r_gap <= r_gap - GW'(1);
            end

            if (w_reload) begin
                r_count <= '0;
                r_ovf   <= 1'b0;
            end else if (w_capture) begin
                if (w_room) begin
                    r_count <= r_count + CW'(1);
                end else begin
                    r_ovf <= 1'b1;
                end
            end

            if (w_capture || ((r_state == S_COLLECT) && i_pkt_eop)) begin
                r_timer <= TIMER_INIT;
            end else if ((r_state == S_DRAIN) && (r_timer != '0)) begin
                r_timer <= r_timer - TW'(1);
            end

            if (w_reload) begin
                r_widx <= '0;
            end else if (w_hs) begin
                r_widx <= w_tlast ? '0 : (r_widx + CW'(1));
            end
        end
    end

    // Rule ID storage; contents are only read below r_count so no reset.
    always_ff @(posedge i_clk) begin
        if (w_capture && w_room) begin
            r_buf[r_count[IW-1:0]] <= i_match_rule_ID;
        end
    end

    assign o_match_release = w_capture;
    assign o_pkt_ready     = r_pkt_ready;
    assign o_reload        = w_reload;
    assign o_m_axis_tdata  = w_tdata;
    assign o_m_axis_tvalid = w_tvalid;
    assign o_m_axis_tlast  = w_tlast;

endmodule

// File: tb/tb_sme_match_collector.sv
// -----------------------------------------------------------------------------
// tb_sme_match_collector
//
// Drives sme_match_collector with an emulated SME matcher (pending rule IDs
// that stay visible for a configurable number of stale cycles after each
// release) and a sink with configurable backpressure. Expected messages are
// computed from the list of presented IDs: header {overflow, kept count}
// followed by the first MAX_MATCHES IDs.
// -----------------------------------------------------------------------------
module tb_sme_match_collector;

    localparam int MAX_MATCHES  = 8;
    localparam int DRAIN_CYCLES = 16;
    localparam int RELEASE_GAP  = 2;
    localparam int CYCLE_BUDGET = 600;
    localparam int NO_LIMIT     = 1000000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        matchValid = 1'b0;
    logic [15:0] matchId = '0;
    logic        matchRelease;
    logic        pktEop = 1'b0;
    logic        pktReady;
    logic        reload;
    logic [15:0] tdata;
    logic        tvalid;
    logic        tlast;
    logic        tready = 1'b0;

    always #5 clk = ~clk;

    sme_match_collector #(
        .MAX_MATCHES (MAX_MATCHES),
        .DRAIN_CYCLES(DRAIN_CYCLES),
        .RELEASE_GAP (RELEASE_GAP)
    ) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_match_valid  (matchValid),
        .i_match_rule_ID(matchId),
        .o_match_release(matchRelease),
        .i_pkt_eop      (pktEop),
        .o_pkt_ready    (pktReady),
        .o_reload       (reload),
        .o_m_axis_tdata (tdata),
        .o_m_axis_tvalid(tvalid),
        .o_m_axis_tlast (tlast),
        .i_m_axis_tready(tready)
    );

    int assertCount = 0;
    int failCount   = 0;

    // Stimulus, expectation and observation state shared by the tasks.
    logic [15:0] stimIds[$];
    logic [15:0] expWords[$];
    logic [15:0] obsWords[$];
    bit          obsLast[$];
    int          obsReleases;
    int          obsReloads;
    int          obsStallViol;
    int          obsRelOutside;
    int          obsFirstValid;
    int          obsMinRelGap;
    bit          obsTimeout;
    bit          obsReadyAtEop;
    bit          obsReadyAfterEop;
    bit          obsReadyAfterClear;
    bit          obsRstTvalid;
    bit          obsRstReady;
    bit          obsRstReload;

    // Reference message for the IDs in stimIds.
    function automatic void buildExpected();
        int n;
        int kept;
        n    = stimIds.size();
        kept = (n < MAX_MATCHES) ? n : MAX_MATCHES;
        expWords.delete();
        expWords.push_back({(n > MAX_MATCHES) ? 1'b1 : 1'b0, 15'(kept)});
        for (int i = 0; i < kept; i++) expWords.push_back(stimIds[i]);
    endfunction

    // Runs one packet: matcher emulation, eop, sink backpressure and output
    // monitoring. Ends one cycle after reload, after a requested mid-message
    // reset, or when the cycle budget runs out.
    task automatic applyStimulus(input int stale, input int eopDelay, input int bpMode,
                                 input int rstAfter, input int validLimit);
        logic [15:0] pend[$];
        logic [15:0] curId = '0;
        logic [15:0] prevData = '0;
        logic        prevLast = 1'b0;
        bit          prevStall = 1'b0;
        bit          inStale;
        bit          done = 1'b0;
        int          staleLeft = 0;
        int          cyc = 0;
        int          hs = 0;
        int          rstPhase = 0;
        int          reloadCyc = -1;
        int          lastRel = -1000;
        pend = stimIds;
        obsWords.delete();
        obsLast.delete();
        obsReleases = 0;        obsReloads = 0;       obsStallViol = 0;
        obsRelOutside = 0;      obsFirstValid = -1;   obsMinRelGap = 1000;
        obsTimeout = 1'b0;      obsReadyAtEop = 1'b0; obsReadyAfterEop = 1'b1;
        obsReadyAfterClear = 1'b0;
        obsRstTvalid = 1'b1;    obsRstReady = 1'b0;   obsRstReload = 1'b0;
        while (!done) begin
            @(negedge clk);
            rst     = (rstPhase == 1);
            inStale = 1'b0;
            if (cyc >= validLimit) begin
                pend.delete();
                staleLeft = 0;
            end
            if (staleLeft > 0) begin
                matchValid = 1'b1; matchId = curId; inStale = 1'b1;
            end else if (pend.size() > 0) begin
                matchValid = 1'b1; matchId = pend[0];
            end else begin
                matchValid = 1'b0; matchId = 16'($urandom);
            end
            pktEop = (cyc == eopDelay);
            case (bpMode)
                0:       tready = 1'b1;
                1:       tready = (cyc % 2 == 0);
                default: tready = ($urandom_range(0, 1) == 1);
            endcase
            if (rstPhase == 1) tready = 1'b0;
            #1;
            if (rstPhase == 2) begin
                obsRstTvalid = tvalid;
                obsRstReady  = pktReady;
                obsRstReload = reload;
                done = 1'b1;
            end else begin
                if (matchRelease) begin
                    obsReleases++;
                    if (tvalid || reload) obsRelOutside++;
                    if (cyc - lastRel < obsMinRelGap) obsMinRelGap = cyc - lastRel;
                    lastRel = cyc;
                    if (!inStale && pend.size() > 0) curId = pend.pop_front();
                    staleLeft = stale;
                end else if (inStale) begin
                    staleLeft--;
                end
                if (cyc == eopDelay) obsReadyAtEop = pktReady;
                if (cyc == eopDelay + 1) obsReadyAfterEop = pktReady;
                if (prevStall && !(tvalid && tdata == prevData && tlast == prevLast))
                    obsStallViol++;
                if (tvalid && obsFirstValid < 0) obsFirstValid = cyc;
                if (tvalid && tready) begin
                    obsWords.push_back(tdata);
                    obsLast.push_back(tlast);
                    hs++;
                end
                prevStall = tvalid && !tready;
                prevData  = tdata;
                prevLast  = tlast;
                if (reload) begin
                    obsReloads++;
                    reloadCyc = cyc;
                end else if (reloadCyc >= 0 && cyc == reloadCyc + 1) begin
                    obsReadyAfterClear = pktReady;
                    done = 1'b1;
                end
                if (rstPhase == 1) rstPhase = 2;
                else if (rstAfter > 0 && hs == rstAfter) rstPhase = 1;
            end
            cyc++;
            if (!done && cyc >= CYCLE_BUDGET) begin
                obsTimeout = 1'b1;
                done = 1'b1;
            end
        end
        @(negedge clk);
        matchValid = 1'b0;
        pktEop     = 1'b0;
        tready     = 1'b0;
        rst        = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1; matchValid = 1'b0; pktEop = 1'b0; tready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        assertCount++;
        if (tvalid !== 1'b0) begin failCount++; $display("[TB] FAIL reset_tvalid: got %b, expected 0", tvalid); end
        assertCount++;
        if (tlast !== 1'b0 || tdata !== 16'h0000) begin
            failCount++; $display("[TB] FAIL reset_tdata: got %h/%b, expected 0000/0", tdata, tlast);
        end
        assertCount++;
        if (matchRelease !== 1'b0 || reload !== 1'b0) begin
            failCount++; $display("[TB] FAIL reset_pulses: got release=%b reload=%b, expected 0/0", matchRelease, reload);
        end
        assertCount++;
        if (pktReady !== 1'b1) begin failCount++; $display("[TB] FAIL reset_ready: got %b, expected 1", pktReady); end
    endtask

    task automatic test_no_matches();
        stimIds.delete();
        buildExpected();
        applyStimulus(0, 2, 0, 0, NO_LIMIT);
        assertCount++;
        if (obsTimeout) begin failCount++; $display("[TB] FAIL t1_timeout: got timeout, expected reload"); end
        assertCount++;
        if (obsWords.size() !== 1 || obsWords[0] !== 16'h0000 || obsLast[0] !== 1'b1) begin
            failCount++; $display("[TB] FAIL t1_message: got %0d words, expected one 0000 with tlast", obsWords.size());
        end
        assertCount++;
        if (obsFirstValid - 2 !== DRAIN_CYCLES + 2) begin
            failCount++; $display("[TB] FAIL t1_latency: got %0d, expected %0d", obsFirstValid - 2, DRAIN_CYCLES + 2);
        end
        assertCount++;
        if (obsReadyAtEop !== 1'b1 || obsReadyAfterEop !== 1'b0) begin
            failCount++; $display("[TB] FAIL t1_ready_fall: got %b->%b, expected 1->0", obsReadyAtEop, obsReadyAfterEop);
        end
        assertCount++;
        if (obsReloads !== 1 || obsReadyAfterClear !== 1'b1) begin
            failCount++; $display("[TB] FAIL t1_reload: got reloads=%0d ready=%b, expected 1/1", obsReloads, obsReadyAfterClear);
        end
        assertCount++;
        if (obsReleases !== 0) begin failCount++; $display("[TB] FAIL t1_releases: got %0d, expected 0", obsReleases); end
    endtask

    task automatic test_three_matches();
        stimIds = '{16'h0011, 16'h0022, 16'h0033};
        buildExpected();
        applyStimulus(2, 1, 0, 0, NO_LIMIT);
        assertCount++;
        if (obsReleases !== 3 || obsRelOutside !== 0) begin
            failCount++; $display("[TB] FAIL t2_releases: got %0d (outside %0d), expected 3 (0)", obsReleases, obsRelOutside);
        end
        assertCount++;
        if (obsWords.size() !== expWords.size()) begin
            failCount++; $display("[TB] FAIL t2_len: got %0d, expected %0d", obsWords.size(), expWords.size());
        end else begin
            for (int i = 0; i < expWords.size(); i++) begin
                assertCount++;
                if (obsWords[i] !== expWords[i] || obsLast[i] !== (i == expWords.size() - 1)) begin
                    failCount++; $display("[TB] FAIL t2_word%0d: got %h/%b, expected %h/%b", i, obsWords[i], obsLast[i], expWords[i], i == expWords.size() - 1);
                end
            end
        end
        assertCount++;
        if (obsReloads !== 1 || obsTimeout) begin
            failCount++; $display("[TB] FAIL t2_reload: got %0d (timeout %b), expected 1", obsReloads, obsTimeout);
        end
    endtask

    task automatic test_stale_valid();
        int expCaps;
        expCaps = (13 + RELEASE_GAP) / (RELEASE_GAP + 1);
        stimIds = '{16'hABCD};
        applyStimulus(1000, 20, 0, 0, 13);
        stimIds.delete();
        for (int i = 0; i < expCaps; i++) stimIds.push_back(16'hABCD);
        buildExpected();
        assertCount++;
        if (obsReleases !== expCaps) begin
            failCount++; $display("[TB] FAIL t3_releases: got %0d, expected %0d", obsReleases, expCaps);
        end
        assertCount++;
        if (obsMinRelGap < RELEASE_GAP + 1) begin
            failCount++; $display("[TB] FAIL t3_spacing: got %0d, expected >= %0d", obsMinRelGap, RELEASE_GAP + 1);
        end
        assertCount++;
        if (obsWords.size() !== expWords.size() || obsWords[0] !== expWords[0]) begin
            failCount++; $display("[TB] FAIL t3_message: got %0d words hdr %h, expected %0d hdr %h",
                                  obsWords.size(), (obsWords.size() > 0) ? obsWords[0] : 16'hxxxx, expWords.size(), expWords[0]);
        end
    endtask

    task automatic test_overflow();
        stimIds.delete();
        for (int i = 0; i < 10; i++) stimIds.push_back(16'($urandom));
        buildExpected();
        applyStimulus(1, 3, 0, 0, NO_LIMIT);
        assertCount++;
        if (obsReleases !== 10) begin failCount++; $display("[TB] FAIL t4_releases: got %0d, expected 10", obsReleases); end
        assertCount++;
        if (obsWords.size() !== expWords.size()) begin
            failCount++; $display("[TB] FAIL t4_len: got %0d, expected %0d", obsWords.size(), expWords.size());
        end else begin
            for (int i = 0; i < expWords.size(); i++) begin
                assertCount++;
                if (obsWords[i] !== expWords[i] || obsLast[i] !== (i == expWords.size() - 1)) begin
                    failCount++; $display("[TB] FAIL t4_word%0d: got %h/%b, expected %h/%b", i, obsWords[i], obsLast[i], expWords[i], i == expWords.size() - 1);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        stimIds.delete();
        for (int i = 0; i < 5; i++) stimIds.push_back(16'($urandom));
        buildExpected();
        applyStimulus(0, 0, 1, 0, NO_LIMIT);
        assertCount++;
        if (obsStallViol !== 0) begin failCount++; $display("[TB] FAIL t5_stall: got %0d unstable stalls, expected 0", obsStallViol); end
        assertCount++;
        if (obsWords.size() !== expWords.size()) begin
            failCount++; $display("[TB] FAIL t5_len: got %0d, expected %0d", obsWords.size(), expWords.size());
        end else begin
            for (int i = 0; i < expWords.size(); i++) begin
                assertCount++;
                if (obsWords[i] !== expWords[i]) begin
                    failCount++; $display("[TB] FAIL t5_word%0d: got %h, expected %h", i, obsWords[i], expWords[i]);
                end
            end
        end
        assertCount++;
        if (obsReloads !== 1) begin failCount++; $display("[TB] FAIL t5_reload: got %0d, expected 1", obsReloads); end
    endtask

    task automatic test_reset_mid_emit();
        stimIds = '{16'h1234, 16'h5678, 16'h9ABC};
        buildExpected();
        applyStimulus(0, 1, 0, 2, NO_LIMIT);
        assertCount++;
        if (obsWords.size() !== 2 || obsWords[0] !== expWords[0] || obsWords[1] !== expWords[1]) begin
            failCount++; $display("[TB] FAIL t6_partial: got %0d words, expected %h,%h", obsWords.size(), expWords[0], expWords[1]);
        end
        assertCount++;
        if (obsRstTvalid !== 1'b0) begin failCount++; $display("[TB] FAIL t6_tvalid: got %b, expected 0", obsRstTvalid); end
        assertCount++;
        if (obsRstReload !== 1'b0 || obsReloads !== 0) begin
            failCount++; $display("[TB] FAIL t6_reload: got %b/%0d, expected 0/0", obsRstReload, obsReloads);
        end
        assertCount++;
        if (obsRstReady !== 1'b1) begin failCount++; $display("[TB] FAIL t6_ready: got %b, expected 1", obsRstReady); end
        stimIds = '{16'h0F0F, 16'hF0F0};
        buildExpected();
        applyStimulus(2, 0, 0, 0, NO_LIMIT);
        assertCount++;
        if (obsWords.size() !== 3 || obsWords[0] !== expWords[0] || obsWords[1] !== expWords[1]
            || obsWords[2] !== expWords[2] || obsLast[2] !== 1'b1) begin
            failCount++; $display("[TB] FAIL t6_next_packet: got %0d words, expected %h,%h,%h", obsWords.size(), expWords[0], expWords[1], expWords[2]);
        end
    endtask

    task automatic test_random_packets();
        int n;
        for (int p = 0; p < 5; p++) begin
            n = $urandom_range(0, 11);
            stimIds.delete();
            for (int i = 0; i < n; i++) stimIds.push_back(16'($urandom));
            buildExpected();
            applyStimulus($urandom_range(0, RELEASE_GAP), $urandom_range(0, 12), 2, 0, NO_LIMIT);
            assertCount++;
            if (obsReleases !== n || obsRelOutside !== 0 || obsTimeout) begin
                failCount++; $display("[TB] FAIL rnd%0d_releases: got %0d (outside %0d, timeout %b), expected %0d", p, obsReleases, obsRelOutside, obsTimeout, n);
            end
            assertCount++;
            if (obsStallViol !== 0 || obsReloads !== 1) begin
                failCount++; $display("[TB] FAIL rnd%0d_flow: got stalls=%0d reloads=%0d, expected 0/1", p, obsStallViol, obsReloads);
            end
            assertCount++;
            if (obsWords.size() !== expWords.size()) begin
                failCount++; $display("[TB] FAIL rnd%0d_len: got %0d, expected %0d", p, obsWords.size(), expWords.size());
            end else begin
                for (int i = 0; i < expWords.size(); i++) begin
                    assertCount++;
                    if (obsWords[i] !== expWords[i] || obsLast[i] !== (i == expWords.size() - 1)) begin
                        failCount++; $display("[TB] FAIL rnd%0d_word%0d: got %h/%b, expected %h/%b", p, i, obsWords[i], obsLast[i], expWords[i], i == expWords.size() - 1);
                    end
                end
            end
        end
    endtask

    initial begin
        $display("[TB] starting sme_match_collector bench");
        test_reset();
        test_no_matches();
        test_three_matches();
        test_stale_valid();
        test_overflow();
        test_backpressure();
        test_reset_mid_emit();
        test_random_packets();
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
